// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Request captured from the winning port at grant time.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory strobes around the arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    // Arbiter view.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_read, mem_write, mem_addr, mem_data_in
    );

    // Requesters and memory view.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_read, mem_write, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; last names the previous winner.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone request wins; on a tie the requester that did not win last time goes.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req0 & (~req1 | last);
        gnt[1] = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between two requesters: grant, one access cycle,
// then a one-cycle acknowledge carrying registered read data.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state;
    mem_req_t          req_q;
    mem_req_t          req_sel;
    logic              last;
    logic [1:0]        gnt;
    logic [1:0]        gnt_q;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              busy_q;
    logic              rd_q;
    logic              wr_q;

    rr_arb2 u_arb (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (last),
        .gnt  (gnt)
    );

    // Steer the winning port's payload toward the request latch.
    always_comb begin
        req_sel = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
        if (gnt[1]) begin
            req_sel = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
        end
    end

    // Sequencer: latch the grant, strobe memory for one cycle, then acknowledge.
    // Strobes are registered so an asynchronous reset removes them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            gnt_q    <= 2'b00;
            req_q    <= '0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        state  <= ACCESS;
                        gnt_q  <= gnt;
                        last   <= gnt[1];
                        req_q  <= req_sel;
                        busy_q <= 1'b1;
                        wr_q   <= req_sel.we;
                        rd_q   <= ~req_sel.we;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    wr_q  <= 1'b0;
                    rd_q  <= 1'b0;
                    ack_q <= gnt_q;
                    if (!req_q.we) begin
                        if (gnt_q[0]) rdata0_q <= bus.mem_data_out;
                        if (gnt_q[1]) rdata1_q <= bus.mem_data_out;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ack_q  <= 2'b00;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ack_q  <= 2'b00;
                    busy_q <= 1'b0;
                    wr_q   <= 1'b0;
                    rd_q   <= 1'b0;
                end
            endcase
        end
    end

    // Address and write data hold the last latched request between accesses.
    assign bus.mem_addr    = req_q.addr;
    assign bus.mem_data_in = req_q.wdata;
    assign bus.mem_read    = rd_q;
    assign bus.mem_write   = wr_q;
    assign bus.ack0        = ack_q[0];
    assign bus.ack1        = ack_q[1];
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32x8 memory attached.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: synchronous write, combinational read.
    logic [DATA_W-1:0] mem [32];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_data_in;
    end
    assign bus.mem_data_out = mem[bus.mem_addr];

    // Event counters sampled at the active edge.
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int wr_cnt   = 0;
    int both_cnt = 0;
    always @(posedge clk) begin
        if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
        if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
        if (bus.mem_write) wr_cnt <= wr_cnt + 1;
        if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Single-requester transaction starting at a falling edge with the FSM idle.
    task automatic txn(input int p, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                       input string tag);
        drive(p, 1'b1, we, a, d);
        @(negedge clk);
        check({tag, "_wr"},   bus.mem_write, we);
        check({tag, "_rd"},   bus.mem_read, !we);
        check({tag, "_addr"}, bus.mem_addr, a);
        @(negedge clk);
        check({tag, "_ack"}, (p == 0) ? bus.ack0 : bus.ack1, 1'b1);
        if (!we) check({tag, "_rdata"}, (p == 0) ? bus.rdata0 : bus.rdata1, exp_rd);
        drive(p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    int w0, a0, a1, n;
    logic order [8];

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ack0", bus.ack0, 1'b0);
        check("rst_ack1", bus.ack1, 1'b0);
        check("rst_rdata0", bus.rdata0, 8'h00);
        check("rst_rdata1", bus.rdata1, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 5'd0);
        check("rst_mem_data_in", bus.mem_data_in, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Write then read, single requester
        w0 = wr_cnt;
        drive(0, 1'b1, 1'b1, 5'd5, 8'hA5);
        @(negedge clk);
        check("t1_access_write", bus.mem_write, 1'b1);
        check("t1_access_read", bus.mem_read, 1'b0);
        check("t1_access_addr", bus.mem_addr, 5'd5);
        check("t1_access_data", bus.mem_data_in, 8'hA5);
        check("t1_access_busy", bus.busy, 1'b1);
        check("t1_access_noack", bus.ack0, 1'b0);
        @(negedge clk);
        check("t1_done_ack0", bus.ack0, 1'b1);
        check("t1_done_write_off", bus.mem_write, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t1_idle_ack0", bus.ack0, 1'b0);
        check("t1_idle_busy", bus.busy, 1'b0);
        check("t1_idle_addr_hold", bus.mem_addr, 5'd5);
        check("t1_write_cycles", wr_cnt - w0, 1);
        txn(0, 1'b0, 5'd5, 8'h00, 8'hA5, "t1_read");
        check("t1_no_ack1", ack1_cnt, 0);

        // Simultaneous first request after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 5'd1, 8'h11);
        drive(1, 1'b1, 1'b1, 5'd2, 8'h22);
        @(negedge clk);
        check("t2_first_addr", bus.mem_addr, 5'd1);
        check("t2_first_data", bus.mem_data_in, 8'h11);
        @(negedge clk);
        check("t2_ack0_e2", bus.ack0, 1'b1);
        check("t2_ack1_e2", bus.ack1, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("t2_second_addr", bus.mem_addr, 5'd2);
        check("t2_second_write", bus.mem_write, 1'b1);
        @(negedge clk);
        check("t2_ack1_e5", bus.ack1, 1'b1);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        txn(0, 1'b0, 5'd1, 8'h00, 8'h11, "t2_rb1");
        txn(1, 1'b0, 5'd2, 8'h00, 8'h22, "t2_rb2");

        // Fairness: both read continuously for eight grants
        drive(0, 1'b1, 1'b0, 5'd1, 8'h00);
        drive(1, 1'b1, 1'b0, 5'd2, 8'h00);
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                order[n] = bus.ack1;
                if (bus.ack1) check("t3_rdata1", bus.rdata1, 8'h22);
                else          check("t3_rdata0", bus.rdata0, 8'h11);
                n++;
                if (n == 8) begin
                    drive(0, 1'b0, 1'b0, '0, '0);
                    drive(1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        @(negedge clk);
        check("t3_ack_count", n, 8);
        for (int i = 0; i < n; i++) check($sformatf("t3_order%0d", i), order[i], i % 2);
        check("t3_never_both", both_cnt, 0);

        // Read/write contention on one address
        txn(1, 1'b1, 5'd3, 8'h33, 8'h00, "t4_pre");
        drive(0, 1'b1, 1'b1, 5'd3, 8'h77);
        drive(1, 1'b1, 1'b0, 5'd3, 8'h00);
        @(negedge clk);
        check("t4_first_write", bus.mem_write, 1'b1);
        @(negedge clk);
        check("t4_ack0", bus.ack0, 1'b1);
        check("t4_no_ack1", bus.ack1, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        check("t4_second_read", bus.mem_read, 1'b1);
        @(negedge clk);
        check("t4_ack1", bus.ack1, 1'b1);
        check("t4_rdata1", bus.rdata1, 8'h77);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset during write access
        txn(0, 1'b1, 5'd4, 8'h44, 8'h00, "t5_pre");
        drive(0, 1'b1, 1'b1, 5'd4, 8'hFF);
        @(negedge clk);
        check("t5_access_write", bus.mem_write, 1'b1);
        a0 = ack0_cnt;
        a1 = ack1_cnt;
        #2 rst = 1'b1;
        #1;
        check("t5_async_write_drop", bus.mem_write, 1'b0);
        check("t5_async_read_drop", bus.mem_read, 1'b0);
        check("t5_async_busy_drop", bus.busy, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
        txn(1, 1'b0, 5'd4, 8'h00, 8'h44, "t5_rb");

        // Late request while busy
        drive(0, 1'b1, 1'b1, 5'd6, 8'h66);
        @(negedge clk);
        check("t6_busy", bus.busy, 1'b1);
        drive(1, 1'b1, 1'b0, 5'd6, 8'h00);
        @(negedge clk);
        check("t6_ack0", bus.ack0, 1'b1);
        check("t6_ack1_early", bus.ack1, 1'b0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t6_idle_busy", bus.busy, 1'b0);
        check("t6_idle_no_read", bus.mem_read, 1'b0);
        @(negedge clk);
        check("t6_access_read", bus.mem_read, 1'b1);
        check("t6_access_addr", bus.mem_addr, 5'd6);
        check("t6_access_no_ack1", bus.ack1, 1'b0);
        @(negedge clk);
        check("t6_ack1", bus.ack1, 1'b1);
        check("t6_rdata1", bus.rdata1, 8'h66);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("end_never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
